// File: rtl/vga_rect_plotter.sv
// ============================================================================
//  Module   : vga_rect_plotter
//  Purpose  : Rectangle/pixel/clear drawing engine, one pixel per clock for a
//             VGA pixel port, with start/busy/done command handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module vga_rect_plotter #(
   parameter int X_BITS     = 8,
   parameter int Y_BITS     = 7,
   parameter int COLOR_BITS = 3,
   parameter int X_MAX      = 159,
   parameter int Y_MAX      = 119
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [X_BITS-1:0]     x0,
   input  logic [Y_BITS-1:0]     y0,
   input  logic [X_BITS-1:0]     w,
   input  logic [Y_BITS-1:0]     h,
   input  logic [COLOR_BITS-1:0] color,
   output logic [X_BITS-1:0]     VGA_X,
   output logic [Y_BITS-1:0]     VGA_Y,
   output logic [COLOR_BITS-1:0] VGA_COLOR,
   output logic                  plot,
   output logic                  busy,
   output logic                  done
);

   localparam int XW = X_BITS + 1;
   localparam int YW = Y_BITS + 1;

   localparam logic [XW-1:0] c_x_max  = XW'(X_MAX);
   localparam logic [YW-1:0] c_y_max  = YW'(Y_MAX);
   localparam logic [XW-1:0] c_x_full = XW'(X_MAX + 1);
   localparam logic [YW-1:0] c_y_full = YW'(Y_MAX + 1);
   localparam logic [XW-1:0] c_x_one  = XW'(1);
   localparam logic [YW-1:0] c_y_one  = YW'(1);

   localparam logic [1:0] c_mode_pixel   = 2'b00;
   localparam logic [1:0] c_mode_outline = 2'b10;
   localparam logic [1:0] c_mode_clear   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              mode_q, mode_d;
   logic [XW-1:0]           x0_q, x0_d, xe_q, xe_d, x_q, x_d;
   logic [YW-1:0]           y0_q, y0_d, ye_q, ye_d, y_q, y_d;
   logic [COLOR_BITS-1:0]   color_q, color_d;
   logic                    plot_q, plot_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic [XW-1:0]           w_eff_x0, w_eff_w, w_eff_xe;
   logic [YW-1:0]           w_eff_y0, w_eff_h, w_eff_ye;
   logic                    w_zero;

   // Coordinates carry one extra bit so the far edge never wraps to 0.
   function automatic logic pixel_on(
      input logic [1:0]    m,
      input logic [XW-1:0] px, xa, xb,
      input logic [YW-1:0] py, ya, yb
   );
      logic border;
      border = (px == xa) || (px == xb) || (py == ya) || (py == yb);
      return (px <= c_x_max) && (py <= c_y_max) &&
             ((m != c_mode_outline) || border);
   endfunction

   always_comb begin
      w_eff_x0 = {1'b0, x0};
      w_eff_y0 = {1'b0, y0};
      w_eff_w  = {1'b0, w};
      w_eff_h  = {1'b0, h};
      if (mode == c_mode_pixel) begin
         w_eff_w = c_x_one;
         w_eff_h = c_y_one;
      end else if (mode == c_mode_clear) begin
         w_eff_x0 = '0;
         w_eff_y0 = '0;
         w_eff_w  = c_x_full;
         w_eff_h  = c_y_full;
      end
      w_eff_xe = w_eff_x0 + w_eff_w - c_x_one;
      w_eff_ye = w_eff_y0 + w_eff_h - c_y_one;
      w_zero   = (w_eff_w == '0) || (w_eff_h == '0);
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      x0_d    = x0_q;
      xe_d    = xe_q;
      x_d     = x_q;
      y0_d    = y0_q;
      ye_d    = ye_q;
      y_d     = y_q;
      color_d = color_q;
      plot_d  = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = mode;
               color_d = color;
               if (w_zero) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_DRAW;
                  x0_d    = w_eff_x0;
                  xe_d    = w_eff_xe;
                  x_d     = w_eff_x0;
                  y0_d    = w_eff_y0;
                  ye_d    = w_eff_ye;
                  y_d     = w_eff_y0;
                  busy_d  = 1'b1;
                  plot_d  = pixel_on(mode, w_eff_x0, w_eff_x0, w_eff_xe,
                                     w_eff_y0, w_eff_y0, w_eff_ye);
               end
            end
         end
         S_DRAW: begin
            if ((x_q == xe_q) && (y_q == ye_q)) begin
               state_d = S_FIN;
               done_d  = 1'b1;
            end else begin
               busy_d = 1'b1;
               if (x_q == xe_q) begin
                  x_d = x0_q;
                  y_d = y_q + c_y_one;
               end else begin
                  x_d = x_q + c_x_one;
               end
               plot_d = pixel_on(mode_q, x_d, x0_q, xe_q, y_d, y0_q, ye_q);
            end
         end
         S_FIN: begin
            // Zero-size commands arrive here with done low; raise it once.
            if (!done_q) begin
               done_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         x0_q    <= '0;
         xe_q    <= '0;
         x_q     <= '0;
         y0_q    <= '0;
         ye_q    <= '0;
         y_q     <= '0;
         color_q <= '0;
         plot_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         x0_q    <= x0_d;
         xe_q    <= xe_d;
         x_q     <= x_d;
         y0_q    <= y0_d;
         ye_q    <= ye_d;
         y_q     <= y_d;
         color_q <= color_d;
         plot_q  <= plot_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign VGA_X     = x_q[X_BITS-1:0];
   assign VGA_Y     = y_q[Y_BITS-1:0];
   assign VGA_COLOR = color_q;
   assign plot      = plot_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_rect_plotter.sv
// ============================================================================
//  Module   : tb_vga_rect_plotter
//  Purpose  : Directed self-checking bench for vga_rect_plotter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_rect_plotter;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic [7:0] x0;
   logic [6:0] y0;
   logic [7:0] w;
   logic [6:0] h;
   logic [2:0] color;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_color;
   logic       plot;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   int         r_busy, r_plot, r_done_at;
   logic [7:0] r_last_x;
   logic [6:0] r_last_y;
   logic [2:0] r_last_c;
   logic [7:0] log_x [16];
   logic [6:0] log_y [16];
   logic [2:0] log_c [16];
   logic [15:0] log_p;
   int         n_done, n_busy;

   vga_rect_plotter #(
      .X_BITS(8), .Y_BITS(7), .COLOR_BITS(3), .X_MAX(159), .Y_MAX(119)
   ) dut (
      .CLOCK_50  (clk),
      .reset     (rst),
      .start     (start),
      .mode      (mode),
      .x0        (x0),
      .y0        (y0),
      .w         (w),
      .h         (h),
      .color     (color),
      .VGA_X     (vga_x),
      .VGA_Y     (vga_y),
      .VGA_COLOR (vga_color),
      .plot      (plot),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issues one command, scrambles the command inputs afterwards, and logs
   // the pixel stream until done (bounded).
   task automatic run_cmd(input logic [1:0] m, input logic [7:0] xs, input logic [6:0] ys,
                          input logic [7:0] ws, input logic [6:0] hs, input logic [2:0] c,
                          input int poke_at);
      bit got;
      @(negedge clk);
      start = 1'b1; mode = m; x0 = xs; y0 = ys; w = ws; h = hs; color = c;
      @(posedge clk);
      #1;
      start = 1'b0; mode = 2'b11; x0 = 8'hAA; y0 = 7'h55; w = 8'hFF; h = 7'h7F; color = ~c;
      r_busy = 0; r_plot = 0; r_done_at = -1; got = 1'b0; log_p = '0;
      r_last_x = '0; r_last_y = '0; r_last_c = '0;
      for (int i = 0; i < 25000 && !got; i++) begin
         @(negedge clk);
         start = (i == poke_at);
         if (done) begin
            got = 1'b1;
            r_done_at = i;
            check("busy_low_at_done", busy, 0);
         end else begin
            if (busy) r_busy++;
            if (plot) begin
               r_plot++;
               r_last_x = vga_x; r_last_y = vga_y; r_last_c = vga_color;
            end
            if (i < 16) begin
               log_x[i] = vga_x; log_y[i] = vga_y; log_c[i] = vga_color; log_p[i] = plot;
            end
         end
      end
      start = 1'b0;
      check("done_seen", got, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; mode = '0; x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
      #1 rst = 1'b1;
      #1;
      check("rst_plot", plot, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_xyc", {vga_x, vga_y, vga_color}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single pixel
      run_cmd(2'b00, 8'd10, 7'd20, 8'd0, 7'd0, 3'd5, -1);
      check("pix_busy", r_busy, 1);
      check("pix_plot", r_plot, 1);
      check("pix_x", log_x[0], 10);
      check("pix_y", log_y[0], 20);
      check("pix_c", log_c[0], 5);
      check("pix_done_at", r_done_at, 1);

      // Filled rectangle raster order
      run_cmd(2'b01, 8'd2, 7'd3, 8'd3, 7'd2, 3'd6, -1);
      check("fill_busy", r_busy, 6);
      check("fill_plot", r_plot, 6);
      check("fill_done_at", r_done_at, 6);
      check("fill_mask", log_p[5:0], 6'b111111);
      check("fill_c", log_c[0], 6);
      begin
         logic [7:0] ex [6];
         logic [6:0] ey [6];
         ex = '{8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4};
         ey = '{7'd3, 7'd3, 7'd3, 7'd4, 7'd4, 7'd4};
         for (int i = 0; i < 6; i++) begin
            check($sformatf("fill_x%0d", i), log_x[i], ex[i]);
            check($sformatf("fill_y%0d", i), log_y[i], ey[i]);
         end
      end

      // Outline: interior (1,1)(2,1)(1,2)(2,2) not plotted
      run_cmd(2'b10, 8'd0, 7'd0, 8'd4, 7'd4, 3'd1, -1);
      check("outl_busy", r_busy, 16);
      check("outl_plot", r_plot, 12);
      check("outl_mask", log_p, 16'hF99F);

      // Clipping at the right/bottom edge, no wrap
      run_cmd(2'b01, 8'd158, 7'd118, 8'd4, 7'd3, 3'd2, -1);
      check("clip_busy", r_busy, 12);
      check("clip_plot", r_plot, 4);
      check("clip_mask", log_p[11:0], 12'h033);
      check("clip_x2", log_x[2], 160);
      check("clip_last", {r_last_x, r_last_y}, {8'd159, 7'd119});

      // Beyond 2^X_BITS-1: outputs show low bits, all clipped
      run_cmd(2'b01, 8'd254, 7'd0, 8'd4, 7'd1, 3'd3, -1);
      check("wrap_busy", r_busy, 4);
      check("wrap_plot", r_plot, 0);
      check("wrap_x2", log_x[2], 0);

      // Clear screen
      run_cmd(2'b11, 8'd50, 7'd50, 8'd3, 7'd3, 3'd0, -1);
      check("clr_busy", r_busy, 19200);
      check("clr_plot", r_plot, 19200);
      check("clr_done_at", r_done_at, 19200);
      check("clr_last", {r_last_x, r_last_y}, {8'd159, 7'd119});
      check("clr_color", r_last_c, 0);

      // Zero-width rectangle
      run_cmd(2'b01, 8'd3, 7'd3, 8'd0, 7'd4, 3'd7, -1);
      check("zero_busy", r_busy, 0);
      check("zero_plot", r_plot, 0);
      check("zero_done_at", r_done_at, 1);

      // start while busy is ignored
      run_cmd(2'b01, 8'd20, 7'd30, 8'd4, 7'd2, 3'd2, 2);
      check("poke_busy", r_busy, 8);
      check("poke_plot", r_plot, 8);
      check("poke_done_at", r_done_at, 8);
      @(negedge clk);
      check("poke_idle", busy, 0);

      // Reset mid-rectangle
      @(negedge clk);
      start = 1'b1; mode = 2'b01; x0 = 8'd5; y0 = 7'd5; w = 8'd10; h = 7'd10; color = 3'd3;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_plot", plot, 0);
      check("arst_busy", busy, 0);
      check("arst_xyc", {vga_x, vga_y, vga_color}, 0);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0; n_busy = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (done) n_done++;
         if (busy) n_busy++;
      end
      check("arst_no_done", n_done, 0);
      check("arst_no_busy", n_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
